test_serial_subtractor: RTL and testbench

Bit-serial subtractor that inverts the 8-bit test adder: given a sum `Y` and one addend `A`, it recovers `B = Y - A` one bit per clock. It sits between an `MCPNR_SWITCHES` bank (driving `Y`, `A`, `start`) and an `MCPNR_LIGHTS` bank (showing `B`, `busy`, `done`, `err`). It is the companion round-trip test design to `test_adder`, and exercises sequential placement and routing: shift registers, a borrow flop and an FSM.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_sub_cell.sv | 13 +
 rtl/test_serial_subtractor.sv | 112 +++++++++++
 tb/tb_test_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor test design.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

  // Bit counter must hold 0..WIDTH with headroom for the terminal compare.
  function automatic int sub_cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: d = x - y - bin, bout set when that step borrows.
module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & (y | bin)) | (y & bin);

endmodule

// File: rtl/test_serial_subtractor.sv
// Bit-serial subtractor recovering B = Y - A one bit per clock, LSB first.
// SERIAL_SUB_START_EDGE_EN: launch on rising edge of start instead of its level.
module test_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH:0]   Y,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = sub_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  sub_state_t state, state_next;

  logic [WIDTH:0] ys;
  logic [WIDTH:0] as;
  logic [WIDTH:0] rs;
  logic [WIDTH:0] rs_next;
  logic [CW-1:0]  cnt;
  logic           borrow;
  logic           d;
  logic           bout;
  logic           launch;
  logic           launch_go;
  logic           last_step;

`ifdef SERIAL_SUB_START_EDGE_EN
  logic start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  assign launch = start & ~start_q;
`else
  assign launch = start;
`endif

  // A launch is only honoured outside RUN; requests during RUN are dropped.
  assign launch_go = launch && (state != RUN);
  assign last_step = (state == RUN) && (cnt == LAST_STEP);

  serial_sub_cell u_cell (
    .x    (ys[0]),
    .y    (as[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign rs_next = {d, rs[WIDTH:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch_go) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (launch_go) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // B and err only move at completion, so the lights keep the previous result during RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ys     <= '0;
      as     <= '0;
      rs     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      B      <= '0;
      err    <= 1'b0;
    end else if (launch_go) begin
      ys     <= Y;
      as     <= {1'b0, A};
      rs     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (state == RUN) begin
      ys     <= ys >> 1;
      as     <= as >> 1;
      rs     <= rs_next;
      borrow <= bout;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        B   <= rs_next[WIDTH-1:0];
        err <= bout | rs_next[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_test_serial_subtractor.sv
// Self-checking bench for test_serial_subtractor against an arithmetic model of Y - A.
module tb_test_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W:0]   Y;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         err;

  int           errors;
  int           checks;
  logic [W-1:0] last_b;
  logic         last_err;

  test_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Y     (Y),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_b   = '0;
    last_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (B !== '0) begin
      errors++; $display("[TB] FAIL reset_B: got %h want 00", B);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_err: got %b want 0", err);
    end
  endtask

  // Launch one operation and check it cycle by cycle; optionally disturb inputs mid-run.
  task automatic run_op(input logic [W:0] y, input logic [W-1:0] a, input int disturb_cycle);
    int           yi;
    int           ai;
    int           diff;
    logic [W-1:0] exp_b;
    logic         exp_err;
    yi      = int'(y);
    ai      = int'(a);
    diff    = (yi - ai) & ((1 << (W + 1)) - 1);
    exp_b   = W'(diff);
    exp_err = (yi < ai) || ((yi - ai) >= (1 << W));

    @(negedge clk);
    Y = y; A = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL launch_flags y=%h a=%h: busy=%b done=%b want busy=1 done=0", y, a, busy, done);
    end
    for (int cyc = 1; cyc <= W; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || B !== last_b || err !== last_err) begin
        errors++;
        $display("[TB] FAIL run_hold cyc=%0d: busy=%b done=%b B=%h err=%b want 1 0 %h %b",
                 cyc, busy, done, B, err, last_b, last_err);
      end
      if (cyc == disturb_cycle) begin
        start = 1'b1;
        Y = ~y;
        A = ~a;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL complete_flags y=%h a=%h: done=%b busy=%b want 1 0", y, a, done, busy);
    end
    checks++;
    if (B !== exp_b || err !== exp_err) begin
      errors++;
      $display("[TB] FAIL result y=%h a=%h: B=%h err=%b want B=%h err=%b", y, a, B, err, exp_b, exp_err);
    end
    last_b   = exp_b;
    last_err = exp_err;
  endtask

  task automatic test_directed();
    run_op(9'h0FF, 8'h7F, 0);
    run_op(9'h1FE, 8'hFF, 0);
    run_op(9'h005, 8'h06, 0);
    run_op(9'h1FF, 8'h00, 0);
  endtask

  task automatic test_ignore_start();
    run_op(9'h010, 8'h01, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || B !== 8'h0F) begin
        errors++;
        $display("[TB] FAIL no_relaunch i=%0d: done=%b busy=%b B=%h want 1 0 0f", i, done, busy, B);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    Y = 9'h0AA; A = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_b   = '0;
    last_err = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || B !== '0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b B=%h err=%b want 0 0 00 0", busy, done, B, err);
    end
    run_op(9'h0AA, 8'h11, 0);
  endtask

  task automatic test_round_trip();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   sum;
    for (int i = 0; i < 200; i++) begin
      ra  = W'($urandom_range(0, (1 << W) - 1));
      rb  = W'($urandom_range(0, (1 << W) - 1));
      sum = {1'b0, ra} + {1'b0, rb};
      run_op(sum, ra, 0);
      checks++;
      if (B !== rb || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL round_trip a=%h b=%h: B=%h err=%b want %h 0", ra, rb, B, err, rb);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op((W + 1)'($urandom_range(0, (1 << (W + 1)) - 1)),
             W'($urandom_range(0, (1 << W) - 1)), 0);
    end
  endtask

  task automatic test_start_held();
    int   rises;
    int   exp_rises;
    logic prev_done;
    do_reset();
`ifdef SERIAL_SUB_START_EDGE_EN
    exp_rises = 1;
`else
    exp_rises = 0;
    for (int t = W + 1; t < 30; t += W + 2) exp_rises++;
`endif
    rises     = 0;
    prev_done = 1'b0;
    @(negedge clk);
    Y = 9'h003; A = 8'h01; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done && !prev_done) rises++;
      prev_done = done;
    end
    checks++;
    if (rises !== exp_rises) begin
      errors++;
      $display("[TB] FAIL held_rises: got %0d want %0d", rises, exp_rises);
    end
    checks++;
    if (B !== 8'h02 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_result: B=%h err=%b want 02 0", B, err);
    end
    start = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    Y        = '0;
    A        = '0;
    last_b   = '0;
    last_err = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_round_trip();
    test_random();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
